collision_detector: RTL and testbench
=====================================

# collision_detector

Pixel-rate collision stage between the object renderers and the game-object managers. Samples per-pixel coverage bits from rocks, bullets and ship on every active pixel, accumulates overlaps over a frame, and at frame end publishes frame-long reset masks for rocks and bullets. These masks feed the rock manager's `reset[9:0]`. It also keeps score, lives and game-over state.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `N_ROCKS`, 10: rock count; width of rock vectors.
- `N_BULLETS`, 4: bullet count.
- `LIVES`, 3: starting lives; `LW` = $clog2(LIVES+1).
- `INVULN_FRAMES`, 120: post-hit invulnerability length in frames (2 s at 60 Hz).

Ports:
- `clk`  in  1: pixel clock; one px/py step per cycle.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `px`, `py`  in  10 each: current scan coordinates.
- `rock_pixel`  in  N_ROCKS: bit i = rock i covers (px,py).
- `bullet_pixel`  in  N_BULLETS: bit j = bullet j covers (px,py).
- `ship_pixel`  in  1: ship covers (px,py).
- `rock_reset`  out  N_ROCKS: rocks destroyed last frame; held one frame.
- `bullet_reset`  out  N_BULLETS: bullets consumed last frame; held one frame.
- `ship_hit`  out  1: counted ship hit last frame; held one frame.
- `frame_tick`  out  1: one-cycle pulse on the commit cycle.
- `score`  out  10: rocks destroyed by bullets; saturates at 1023.
- `lives`  out  LW: remaining lives.
- `game_over`  out  1: sticky; set when lives reach 0.

## Operation
- **Stage 1 (registered):** capture `active` = (px<H_ACTIVE && py<V_ACTIVE), `rock_pixel`, `bullet_pixel` and `ship_pixel`.
- **Stage 2 (accumulate):** runs only when stage-1 `active`=1.
  - `pend_rock[i]` |= rock[i] & |bullet.
  - `pend_score[i]` |= rock[i] & |bullet.
  - `pend_bullet[j]` |= bullet[j] & |rock.
  - `pend_ship` |= ship & |rock.
  - `pend_rock[i]` |= rock[i] & ship, only if ship state is PLAYING.
- **Commit:** occurs on the cycle where input px==0 && py==V_ACTIVE.
  - `rock_reset` <= pend_rock.
  - `bullet_reset` <= pend_bullet.
  - `score` <= min(1023, score + popcount(pend_score)), skipped in GAME_OVER.
  - All pend registers cleared.
  - `frame_tick`=1.
  - Outputs hold until the next commit.
- **Ship state machine:** states PLAYING, INVULN, GAME_OVER; evaluated at commit only.
  - PLAYING, pend_ship=1, lives>1: lives-1, `ship_hit`=1, invuln counter = INVULN_FRAMES-1, go to INVULN.
  - PLAYING, pend_ship=1, lives==1: lives=0, `ship_hit`=1, `game_over`=1, go to GAME_OVER.
  - INVULN: pend_ship ignored. Counter decrements each commit. At 0 → PLAYING (the transition uses the commit where the counter reads 0).
  - GAME_OVER: terminal until `reset`. Ship hits and scoring disabled. Rock and bullet masks still published.
- **Combined rules:**
  - Multiple bullets on one rock: +1 score.
  - One bullet over two rocks: +2 score.
  - Rock hit by bullet and ship in the same frame: score +1 and ship hit.

## Timing
- Reset values:
  - `rock_reset`, `bullet_reset`, `ship_hit`, `frame_tick`, `score`, `game_over` = 0.
  - `lives` = LIVES; ship state PLAYING; invuln counter 0; all pend cleared.
- Latency:
  - Pixel overlap → pend set: 2 clocks.
  - Overlap in frame N → visible in outputs from commit N until commit N+1.
- Blanking pixels (stage-1 `active`=0) never accumulate.
- The last active pixel of line V_ACTIVE-1 is accumulated before commit, because horizontal blanking separates it from the commit point.
- `reset` mid-frame: all pend and outputs cleared immediately (asynchronously); hits earlier in that frame are lost.
- Score saturation: at 1022 plus 3 hits → 1023.
- Score never wraps.

## Test plan
- Reset then one idle frame: all masks 0, score 0, lives 3, `frame_tick` pulses once at px=0, py=480.
- `rock_pixel[2]`=1 and `bullet_pixel[1]`=1 at (100,100): after commit, `rock_reset`=0x004, `bullet_reset`=0x2, score=1; both masks return to 0 at the following commit.
- `ship_pixel` with `rock_pixel[5]` at (320,240), plus a repeat overlap every frame: first commit gives lives=2, `ship_hit`=1, `rock_reset`=0x020; no further life loss for 120 frames; the next overlap after that gives lives=1.
- Three ship hits spaced >120 frames apart: lives reaches 0 and `game_over`=1; a later bullet/rock overlap still sets `rock_reset` while score stays unchanged.
- Score preloaded to 1022 via 1022 hit frames (or forced), then one frame with bullet over rocks 0, 1 and 3: score=1023.
- Overlap at (700,100) and at (10,500): no pend set; masks stay 0. Assert `reset` mid-frame after an overlap at (50,50): commit yields 0 masks.

Source files
------------

// File: rtl/collision_detector.sv
// Pixel-rate collision stage: registers per-pixel coverage, accumulates overlaps over a frame,
// and publishes rock/bullet reset masks, score, lives and game-over state at each frame commit.
module collision_detector #(
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int N_ROCKS       = 10,
    parameter int N_BULLETS     = 4,
    parameter int LIVES         = 3,
    parameter int LW            = $clog2(LIVES + 1),
    parameter int INVULN_FRAMES = 120
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           px,
    input  logic [9:0]           py,
    input  logic [N_ROCKS-1:0]   rock_pixel,
    input  logic [N_BULLETS-1:0] bullet_pixel,
    input  logic                 ship_pixel,
    output logic [N_ROCKS-1:0]   rock_reset,
    output logic [N_BULLETS-1:0] bullet_reset,
    output logic                 ship_hit,
    output logic                 frame_tick,
    output logic [9:0]           score,
    output logic [LW-1:0]        lives,
    output logic                 game_over
);

    localparam int IW = (INVULN_FRAMES > 2) ? $clog2(INVULN_FRAMES) : 1;
    localparam logic [9:0]    H_LIM      = 10'(H_ACTIVE);
    localparam logic [9:0]    V_LIM      = 10'(V_ACTIVE);
    localparam logic [IW-1:0] INV_LOAD   = IW'(INVULN_FRAMES - 1);
    localparam logic [LW-1:0] LIVES_INIT = LW'(LIVES);

    typedef enum logic [1:0] {PLAYING, INVULN, GAME_OVER} ship_state_t;

    function automatic logic [9:0] sat_score(input logic [9:0] cur, input logic [N_ROCKS-1:0] hits);
        logic [10:0] sum;
        sum = {1'b0, cur};
        for (int i = 0; i < N_ROCKS; i++) begin
            sum = sum + {10'd0, hits[i]};
        end
        return (sum > 11'd1023) ? 10'd1023 : sum[9:0];
    endfunction

    logic                 vld_p1_q, vld_p1_d;
    logic [N_ROCKS-1:0]   rock_p1_q, rock_p1_d;
    logic [N_BULLETS-1:0] bullet_p1_q, bullet_p1_d;
    logic                 ship_p1_q, ship_p1_d;

    logic [N_ROCKS-1:0]   pend_rock_q, pend_rock_d;
    logic [N_ROCKS-1:0]   pend_score_q, pend_score_d;
    logic [N_BULLETS-1:0] pend_bullet_q, pend_bullet_d;
    logic                 pend_ship_q, pend_ship_d;

    logic [N_ROCKS-1:0]   rock_reset_q, rock_reset_d;
    logic [N_BULLETS-1:0] bullet_reset_q, bullet_reset_d;
    logic                 ship_hit_q, ship_hit_d;
    logic                 frame_tick_q, frame_tick_d;
    logic [9:0]           score_q, score_d;
    logic [LW-1:0]        lives_q, lives_d;
    logic                 game_over_q, game_over_d;
    logic [IW-1:0]        invuln_q, invuln_d;
    ship_state_t          state_q, state_d;

    logic commit;
    logic any_rock;
    logic any_bullet;

    always_comb begin
        commit     = (px == 10'd0) && (py == V_LIM);
        any_rock   = |rock_p1_q;
        any_bullet = |bullet_p1_q;

        vld_p1_d    = (px < H_LIM) && (py < V_LIM);
        rock_p1_d   = rock_pixel;
        bullet_p1_d = bullet_pixel;
        ship_p1_d   = ship_pixel;

        pend_rock_d    = pend_rock_q;
        pend_score_d   = pend_score_q;
        pend_bullet_d  = pend_bullet_q;
        pend_ship_d    = pend_ship_q;
        rock_reset_d   = rock_reset_q;
        bullet_reset_d = bullet_reset_q;
        ship_hit_d     = ship_hit_q;
        frame_tick_d   = 1'b0;
        score_d        = score_q;
        lives_d        = lives_q;
        game_over_d    = game_over_q;
        invuln_d       = invuln_q;
        state_d        = state_q;

        if (commit) begin
            // Frame boundary: publish accumulated hits and start a fresh frame.
            rock_reset_d   = pend_rock_q;
            bullet_reset_d = pend_bullet_q;
            ship_hit_d     = 1'b0;
            frame_tick_d   = 1'b1;
            pend_rock_d    = '0;
            pend_score_d   = '0;
            pend_bullet_d  = '0;
            pend_ship_d    = 1'b0;
            if (state_q != GAME_OVER) begin
                score_d = sat_score(score_q, pend_score_q);
            end
            case (state_q)
                PLAYING: begin
                    if (pend_ship_q) begin
                        ship_hit_d = 1'b1;
                        if (lives_q > LW'(1)) begin
                            lives_d  = lives_q - LW'(1);
                            invuln_d = INV_LOAD;
                            state_d  = INVULN;
                        end else begin
                            lives_d     = '0;
                            game_over_d = 1'b1;
                            state_d     = GAME_OVER;
                        end
                    end
                end
                INVULN: begin
                    if (invuln_q == '0) begin
                        state_d = PLAYING;
                    end else begin
                        invuln_d = invuln_q - IW'(1);
                    end
                end
                GAME_OVER: state_d = GAME_OVER;
                default:   state_d = PLAYING;
            endcase
        end else if (vld_p1_q) begin
            pend_rock_d   = pend_rock_q | (rock_p1_q & {N_ROCKS{any_bullet}});
            pend_score_d  = pend_score_q | (rock_p1_q & {N_ROCKS{any_bullet}});
            pend_bullet_d = pend_bullet_q | (bullet_p1_q & {N_BULLETS{any_rock}});
            pend_ship_d   = pend_ship_q | (ship_p1_q & any_rock);
            if (state_q == PLAYING) begin
                pend_rock_d = pend_rock_d | (rock_p1_q & {N_ROCKS{ship_p1_q}});
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1_q       <= 1'b0;
            rock_p1_q      <= '0;
            bullet_p1_q    <= '0;
            ship_p1_q      <= 1'b0;
            pend_rock_q    <= '0;
            pend_score_q   <= '0;
            pend_bullet_q  <= '0;
            pend_ship_q    <= 1'b0;
            rock_reset_q   <= '0;
            bullet_reset_q <= '0;
            ship_hit_q     <= 1'b0;
            frame_tick_q   <= 1'b0;
            score_q        <= '0;
            lives_q        <= LIVES_INIT;
            game_over_q    <= 1'b0;
            invuln_q       <= '0;
            state_q        <= PLAYING;
        end else begin
            vld_p1_q       <= vld_p1_d;
            rock_p1_q      <= rock_p1_d;
            bullet_p1_q    <= bullet_p1_d;
            ship_p1_q      <= ship_p1_d;
            pend_rock_q    <= pend_rock_d;
            pend_score_q   <= pend_score_d;
            pend_bullet_q  <= pend_bullet_d;
            pend_ship_q    <= pend_ship_d;
            rock_reset_q   <= rock_reset_d;
            bullet_reset_q <= bullet_reset_d;
            ship_hit_q     <= ship_hit_d;
            frame_tick_q   <= frame_tick_d;
            score_q        <= score_d;
            lives_q        <= lives_d;
            game_over_q    <= game_over_d;
            invuln_q       <= invuln_d;
            state_q        <= state_d;
        end
    end

    assign rock_reset   = rock_reset_q;
    assign bullet_reset = bullet_reset_q;
    assign ship_hit     = ship_hit_q;
    assign frame_tick   = frame_tick_q;
    assign score        = score_q;
    assign lives        = lives_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_collision_detector.sv
// Bench for collision_detector: short synthetic frames (a few pixels, then the commit point),
// expected frame results queued at commit and compared when frame_tick appears.
module tb_collision_detector;

    localparam int NR = 10;
    localparam int NB = 4;
    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    px, py;
    logic [NR-1:0] rock_pixel;
    logic [NB-1:0] bullet_pixel;
    logic          ship_pixel;
    logic [NR-1:0] rock_reset;
    logic [NB-1:0] bullet_reset;
    logic          ship_hit;
    logic          frame_tick;
    logic [9:0]    score;
    logic [LW-1:0] lives;
    logic          game_over;

    always #5 clk = ~clk;

    collision_detector dut (
        .clk          (clk),
        .reset        (reset),
        .px           (px),
        .py           (py),
        .rock_pixel   (rock_pixel),
        .bullet_pixel (bullet_pixel),
        .ship_pixel   (ship_pixel),
        .rock_reset   (rock_reset),
        .bullet_reset (bullet_reset),
        .ship_hit     (ship_hit),
        .frame_tick   (frame_tick),
        .score        (score),
        .lives        (lives),
        .game_over    (game_over)
    );

    typedef struct packed {
        logic [9:0] rr;
        logic [3:0] br;
        logic       sh;
        logic [9:0] sc;
        logic [1:0] lv;
        logic       go;
    } exp_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] r;
        logic [3:0] b;
        logic       s;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[10];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk_exp(input logic [9:0] rr, input logic [3:0] br, input logic sh,
                                    input logic [9:0] sc, input logic [1:0] lv, input logic go);
        exp_t e;
        e.rr = rr; e.br = br; e.sh = sh; e.sc = sc; e.lv = lv; e.go = go;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic [9:0] x, input logic [9:0] y, input logic [9:0] r,
                                    input logic [3:0] b, input logic s, input exp_t e);
        vec_t v;
        v.x = x; v.y = y; v.r = r; v.b = b; v.s = s; v.e = e;
        return v;
    endfunction

    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic [9:0] r,
                         input logic [3:0] b, input logic s);
        px = x; py = y; rock_pixel = r; bullet_pixel = b; ship_pixel = s;
        @(posedge clk);
        #1;
    endtask

    // One frame: a single pixel, blanking so it reaches the accumulator, then the commit point.
    task automatic run_frame(input logic [9:0] x, input logic [9:0] y, input logic [9:0] r,
                             input logic [3:0] b, input logic s, input exp_t e);
        drive(x, y, r, b, s);
        drive(10'd700, 10'd0, '0, '0, 1'b0);
        drive(10'd700, 10'd0, '0, '0, 1'b0);
        sb.push_back(e);
        drive(10'd0, 10'd480, '0, '0, 1'b0);
        drive(10'd700, 10'd0, '0, '0, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (frame_tick) begin
            if (sb.size() == 0) begin
                check("unexpected_frame_tick", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("rock_reset", int'(rock_reset), int'(mon_e.rr));
                check("bullet_reset", int'(bullet_reset), int'(mon_e.br));
                check("ship_hit", int'(ship_hit), int'(mon_e.sh));
                check("score", int'(score), int'(mon_e.sc));
                check("lives", int'(lives), int'(mon_e.lv));
                check("game_over", int'(game_over), int'(mon_e.go));
            end
        end
    end

    initial begin
        reset = 1'b1;
        px = 10'd700; py = 10'd0; rock_pixel = '0; bullet_pixel = '0; ship_pixel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_rock_reset", int'(rock_reset), 0);
        check("rst_bullet_reset", int'(bullet_reset), 0);
        check("rst_ship_hit", int'(ship_hit), 0);
        check("rst_frame_tick", int'(frame_tick), 0);
        check("rst_score", int'(score), 0);
        check("rst_lives", int'(lives), 3);
        check("rst_game_over", int'(game_over), 0);

        tbl[0] = mk_vec(10'd700, 10'd0,   10'h000, 4'h0, 1'b0, mk_exp(10'h000, 4'h0, 1'b0, 10'd0, 2'd3, 1'b0));
        tbl[1] = mk_vec(10'd100, 10'd100, 10'h004, 4'h2, 1'b0, mk_exp(10'h004, 4'h2, 1'b0, 10'd1, 2'd3, 1'b0));
        tbl[2] = mk_vec(10'd700, 10'd0,   10'h000, 4'h0, 1'b0, mk_exp(10'h000, 4'h0, 1'b0, 10'd1, 2'd3, 1'b0));
        tbl[3] = mk_vec(10'd700, 10'd100, 10'h001, 4'h1, 1'b0, mk_exp(10'h000, 4'h0, 1'b0, 10'd1, 2'd3, 1'b0));
        tbl[4] = mk_vec(10'd10,  10'd500, 10'h001, 4'h1, 1'b0, mk_exp(10'h000, 4'h0, 1'b0, 10'd1, 2'd3, 1'b0));
        tbl[5] = mk_vec(10'd5,   10'd5,   10'h001, 4'hF, 1'b0, mk_exp(10'h001, 4'hF, 1'b0, 10'd2, 2'd3, 1'b0));
        tbl[6] = mk_vec(10'd20,  10'd30,  10'h030, 4'h1, 1'b0, mk_exp(10'h030, 4'h1, 1'b0, 10'd4, 2'd3, 1'b0));
        tbl[7] = mk_vec(10'd639, 10'd479, 10'h200, 4'h8, 1'b0, mk_exp(10'h200, 4'h8, 1'b0, 10'd5, 2'd3, 1'b0));
        tbl[8] = mk_vec(10'd640, 10'd479, 10'h001, 4'h1, 1'b0, mk_exp(10'h000, 4'h0, 1'b0, 10'd5, 2'd3, 1'b0));
        tbl[9] = mk_vec(10'd320, 10'd240, 10'h020, 4'h0, 1'b1, mk_exp(10'h020, 4'h0, 1'b1, 10'd5, 2'd2, 1'b0));

        for (int i = 0; i < 10; i++) begin
            run_frame(tbl[i].x, tbl[i].y, tbl[i].r, tbl[i].b, tbl[i].s, tbl[i].e);
        end

        // Invulnerability: 120 overlapping frames cost nothing, the next one costs a life.
        for (int k = 0; k < 120; k++) begin
            run_frame(10'd320, 10'd240, 10'h020, 4'h0, 1'b1, mk_exp(10'h000, 4'h0, 1'b0, 10'd5, 2'd2, 1'b0));
        end
        run_frame(10'd320, 10'd240, 10'h020, 4'h0, 1'b1, mk_exp(10'h020, 4'h0, 1'b1, 10'd5, 2'd1, 1'b0));
        for (int k = 0; k < 120; k++) begin
            run_frame(10'd700, 10'd0, 10'h000, 4'h0, 1'b0, mk_exp(10'h000, 4'h0, 1'b0, 10'd5, 2'd1, 1'b0));
        end
        // Last life lost in a frame where the same rock is also shot: score still counts.
        run_frame(10'd320, 10'd240, 10'h020, 4'h1, 1'b1, mk_exp(10'h020, 4'h1, 1'b1, 10'd6, 2'd0, 1'b1));
        run_frame(10'd320, 10'd240, 10'h004, 4'h0, 1'b1, mk_exp(10'h000, 4'h0, 1'b0, 10'd6, 2'd0, 1'b1));
        run_frame(10'd100, 10'd100, 10'h008, 4'h1, 1'b0, mk_exp(10'h008, 4'h1, 1'b0, 10'd6, 2'd0, 1'b1));

        // Reset in mid-frame after an overlap at (50,50).
        drive(10'd50, 10'd50, 10'h001, 4'h1, 1'b0);
        drive(10'd700, 10'd0, '0, '0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_rock_reset", int'(rock_reset), 0);
        check("midrst_bullet_reset", int'(bullet_reset), 0);
        check("midrst_score", int'(score), 0);
        check("midrst_lives", int'(lives), 3);
        check("midrst_game_over", int'(game_over), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_frame(10'd700, 10'd0, 10'h000, 4'h0, 1'b0, mk_exp(10'h000, 4'h0, 1'b0, 10'd0, 2'd3, 1'b0));

        // Score up to 1022, then +3 saturates at 1023 and stays there.
        for (int k = 1; k <= 1022; k++) begin
            run_frame(10'd100, 10'd100, 10'h001, 4'h1, 1'b0, mk_exp(10'h001, 4'h1, 1'b0, 10'(k), 2'd3, 1'b0));
        end
        run_frame(10'd200, 10'd200, 10'h00B, 4'h1, 1'b0, mk_exp(10'h00B, 4'h1, 1'b0, 10'd1023, 2'd3, 1'b0));
        run_frame(10'd200, 10'd200, 10'h001, 4'h1, 1'b0, mk_exp(10'h001, 4'h1, 1'b0, 10'd1023, 2'd3, 1'b0));

        repeat (3) @(posedge clk);
        #2;
        check("pending_frames_left", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
